// File: rtl/mem_selftest_seq_pkg.sv
// rtl/mem_selftest_seq_pkg.sv - shared types, pattern modes and LFSR step for the memory self-test sequencer
package mem_selftest_seq_pkg;

  localparam int CPU_ADDR_W = 27;
  localparam int CPU_DATA_W = 32;

  localparam int MODE_ADDR     = 0;
  localparam int MODE_INV_ADDR = 1;
  localparam int MODE_LFSR     = 2;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] addr;
    logic [CPU_DATA_W-1:0] data;
    logic                  rw;
    logic                  valid;
  } cpu_req_type;

  typedef struct packed {
    logic [CPU_DATA_W-1:0] data;
    logic                  ready;
  } cpu_result_type;

  typedef enum logic [2:0] {
    MST_IDLE,
    MST_WR_REQ,
    MST_WR_WAIT,
    MST_RD_REQ,
    MST_RD_WAIT,
    MST_DONE
  } mst_state_e;

  // Galois form: shift right, fold the polynomial in when a one falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur, input logic [31:0] poly);
    return (cur >> 1) ^ (cur[0] ? poly : 32'h0);
  endfunction

endpackage

// File: rtl/mst_pattern_gen.sv
// rtl/mst_pattern_gen.sv - word index, address and data pattern source for the self-test sequencer
module mst_pattern_gen
  import mem_selftest_seq_pkg::*;
#(
  parameter int              ADDR_W      = 27,
  parameter int              DATA_W      = 32,
  parameter int              N_WORDS     = 16,
  parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
  parameter int              ADDR_STRIDE = 4,
  parameter int              MODE        = 0,
  parameter logic [31:0]     LFSR_POLY   = 32'h8020_0003,
  parameter logic [31:0]     LFSR_SEED   = 32'h3333_3333,
  localparam int             IDX_W       = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  output logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  logic [31:0] lfsr;

  // Address is accumulated rather than multiplied; ADDR_W-bit arithmetic gives the wrap.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      addr <= ADDR_BASE;
      lfsr <= LFSR_SEED;
    end else if (load) begin
      idx  <= '0;
      addr <= ADDR_BASE;
      lfsr <= LFSR_SEED;
    end else if (step) begin
      idx  <= idx + IDX_W'(1);
      addr <= addr + ADDR_W'(ADDR_STRIDE);
      lfsr <= lfsr_next(lfsr, LFSR_POLY);
    end
  end

  always_comb begin
    data = DATA_W'(addr);
    case (MODE)
      MODE_INV_ADDR: data = ~DATA_W'(addr);
      MODE_LFSR:     data = DATA_W'(lfsr);
      default:       data = DATA_W'(addr);
    endcase
  end

  assign last = (idx == IDX_W'(N_WORDS - 1));

endmodule

// File: rtl/mem_selftest_seq.sv
// rtl/mem_selftest_seq.sv - start/done memory exerciser: writes N_WORDS patterns, reads back and scores
module mem_selftest_seq
  import mem_selftest_seq_pkg::*;
#(
  parameter int                ADDR_W      = 27,
  parameter int                DATA_W      = 32,
  parameter int                N_WORDS     = 16,
  parameter logic [ADDR_W-1:0] ADDR_BASE   = '0,
  parameter int                ADDR_STRIDE = 4,
  parameter int                MODE        = 0,
  parameter logic [31:0]       LFSR_POLY   = 32'h8020_0003,
  parameter logic [31:0]       LFSR_SEED   = 32'h3333_3333,
  parameter int                TIMEOUT_CYC = 1024,
  localparam int               IDX_W       = (N_WORDS > 1) ? $clog2(N_WORDS) : 1,
  localparam int               CNT_W       = $clog2(N_WORDS + 1)
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  output logic              req_rw,
  output logic              req_valid,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  err_count,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_data,
  output logic              proto_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  mst_state_e        state;
  logic [TO_W-1:0]   wait_cnt;
  logic [IDX_W-1:0]  gen_idx;
  logic [ADDR_W-1:0] gen_addr;
  logic [DATA_W-1:0] gen_data;
  logic              gen_last;
  logic              gen_load;
  logic              gen_step;
  logic              in_wait;
  logic              expired;
  logic              mismatch;

  assign in_wait  = (state == MST_WR_WAIT) || (state == MST_RD_WAIT);
  assign expired  = (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign mismatch = (rsp_data != gen_data);
  assign gen_load = ((state == MST_IDLE) && start) || ((state == MST_WR_WAIT) && rsp_ready && gen_last);
  assign gen_step = in_wait && rsp_ready && !gen_last;

  mst_pattern_gen #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .N_WORDS    (N_WORDS),
    .ADDR_BASE  (ADDR_BASE),
    .ADDR_STRIDE(ADDR_STRIDE),
    .MODE       (MODE),
    .LFSR_POLY  (LFSR_POLY),
    .LFSR_SEED  (LFSR_SEED)
  ) u_gen (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .load   (gen_load),
    .step   (gen_step),
    .idx    (gen_idx),
    .addr   (gen_addr),
    .data   (gen_data),
    .last   (gen_last)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= MST_IDLE;
      wait_cnt       <= '0;
      req_addr       <= '0;
      req_data       <= '0;
      req_rw         <= 1'b0;
      req_valid      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      proto_err      <= 1'b0;
    end else begin
      case (state)
        MST_IDLE: begin
          if (start) begin
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            proto_err      <= 1'b0;
            busy           <= 1'b1;
            state          <= MST_WR_REQ;
          end
        end
        MST_WR_REQ, MST_RD_REQ: begin
          req_valid <= 1'b1;
          req_addr  <= gen_addr;
          req_data  <= gen_data;
          req_rw    <= (state == MST_WR_REQ);
          wait_cnt  <= '0;
          state     <= (state == MST_WR_REQ) ? MST_WR_WAIT : MST_RD_WAIT;
        end
        MST_WR_WAIT, MST_RD_WAIT: begin
          // A response on the expiry cycle is checked first, so it beats the timeout.
          if (rsp_ready) begin
            req_valid <= 1'b0;
            if (state == MST_RD_WAIT && mismatch) begin
              if (err_count != CNT_W'(N_WORDS)) err_count <= err_count + CNT_W'(1);
              if (err_count == '0) begin
                first_err_idx  <= gen_idx;
                first_err_data <= rsp_data;
              end
            end
            if (!gen_last) begin
              state <= (state == MST_WR_WAIT) ? MST_WR_REQ : MST_RD_REQ;
            end else if (state == MST_WR_WAIT) begin
              state <= MST_RD_REQ;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= !mismatch && (err_count == '0);
              state <= MST_DONE;
            end
          end else if (expired) begin
            req_valid <= 1'b0;
            timeout   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
            state     <= MST_DONE;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        MST_DONE: state <= MST_IDLE;
        default:  state <= MST_IDLE;
      endcase
      if (rsp_ready && !in_wait) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_selftest_seq.sv
// tb/tb_mem_selftest_seq.sv - self-checking bench for mem_selftest_seq with a delayed-ready memory model
module tb_mem_selftest_seq;

  localparam int              AW    = 27;
  localparam int              DW    = 32;
  localparam int              NW    = 4;
  localparam logic [AW-1:0]   BASE0 = '0;
  localparam logic [AW-1:0]   BASE1 = 27'h7FF_FFF8;
  localparam logic [31:0]     POLY  = 32'h8020_0003;
  localparam logic [31:0]     SEED  = 32'h3333_3333;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          rw;
  } req_t;

  typedef struct {
    int         dly;
    logic [3:0] corrupt;
    logic       exp_pass;
    int         exp_err;
    int         exp_fidx;
    logic       exp_to;
  } vec_t;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic start   = 1'b0;

  logic [AW-1:0] req_addr[2];
  logic [DW-1:0] req_data[2];
  logic          req_rw[2];
  logic          req_valid[2];
  logic [DW-1:0] rsp_data[2];
  logic          rsp_ready[2];
  logic          rsp_model[2];
  logic          poke[2] = '{1'b0, 1'b0};
  logic          busy[2];
  logic          done[2];
  logic          pass[2];
  logic          timeout[2];
  logic [2:0]    err_count[2];
  logic [1:0]    first_err_idx[2];
  logic [DW-1:0] first_err_data[2];
  logic          proto_err[2];

  int            total = 0;
  int            bad   = 0;
  req_t          q0[$];
  req_t          q1[$];
  int            dly[2];
  int            dly_cfg[2];
  logic [3:0]    corrupt[2];
  logic [DW-1:0] mem[2][4];
  logic          prev_valid[2];
  int            k_idx;
  vec_t          vecs[6];

  always #5 sys_clk = ~sys_clk;

  assign rsp_ready[0] = rsp_model[0] | poke[0];
  assign rsp_ready[1] = rsp_model[1] | poke[1];

  mem_selftest_seq #(
    .ADDR_W(AW), .DATA_W(DW), .N_WORDS(NW), .ADDR_BASE(BASE0), .ADDR_STRIDE(4),
    .MODE(0), .LFSR_POLY(POLY), .LFSR_SEED(SEED), .TIMEOUT_CYC(16)
  ) dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start),
    .req_addr(req_addr[0]), .req_data(req_data[0]), .req_rw(req_rw[0]), .req_valid(req_valid[0]),
    .rsp_data(rsp_data[0]), .rsp_ready(rsp_ready[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .timeout(timeout[0]),
    .err_count(err_count[0]), .first_err_idx(first_err_idx[0]),
    .first_err_data(first_err_data[0]), .proto_err(proto_err[0])
  );

  mem_selftest_seq #(
    .ADDR_W(AW), .DATA_W(DW), .N_WORDS(NW), .ADDR_BASE(BASE1), .ADDR_STRIDE(4),
    .MODE(2), .LFSR_POLY(POLY), .LFSR_SEED(SEED), .TIMEOUT_CYC(16)
  ) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start),
    .req_addr(req_addr[1]), .req_data(req_data[1]), .req_rw(req_rw[1]), .req_valid(req_valid[1]),
    .rsp_data(rsp_data[1]), .rsp_ready(rsp_ready[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .timeout(timeout[1]),
    .err_count(err_count[1]), .first_err_idx(first_err_idx[1]),
    .first_err_data(first_err_data[1]), .proto_err(proto_err[1])
  );

  function automatic logic [AW-1:0] addr_of(input int g, input int i);
    logic [AW-1:0] a = (g == 0) ? BASE0 : BASE1;
    return a + AW'(4 * i);
  endfunction

  function automatic logic [DW-1:0] data_of(input int g, input int i);
    logic [31:0] l = SEED;
    if (g == 0) return DW'(addr_of(0, i));
    for (int s = 0; s < i; s++) l = (l >> 1) ^ (l[0] ? POLY : 32'h0);
    return l;
  endfunction

  function automatic int widx(input int g, input logic [AW-1:0] a);
    logic [AW-1:0] d = a - ((g == 0) ? BASE0 : BASE1);
    return int'(d[3:2]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int g, input int n);
    req_t e;
    for (int j = 0; j < n; j++) begin
      e.rw   = (j < NW);
      e.addr = addr_of(g, j % NW);
      e.data = data_of(g, j % NW);
      if (g == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic check_req(input int g);
    req_t e;
    if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL unexpected_req dut%0d: got addr %h rw %0d expected no request", g, req_addr[g], req_rw[g]);
      return;
    end
    if (g == 0) e = q0.pop_front();
    else e = q1.pop_front();
    check($sformatf("req%0d_addr", g), 64'(req_addr[g]), 64'(e.addr));
    check($sformatf("req%0d_data", g), 64'(req_data[g]), 64'(e.data));
    check($sformatf("req%0d_rw", g), 64'(req_rw[g]), 64'(e.rw));
  endtask

  // Memory model and request scoreboard: ready is raised on the third waiting cycle by default.
  always @(negedge sys_clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        rsp_model[g]  = 1'b0;
        rsp_data[g]   = '0;
        dly[g]        = 0;
        prev_valid[g] = 1'b0;
      end else begin
        if (req_valid[g] && !prev_valid[g]) check_req(g);
        prev_valid[g] = req_valid[g];
        if (rsp_model[g]) begin
          rsp_model[g] = 1'b0;
        end else if (!req_valid[g]) begin
          dly[g] = 0;
        end else if (dly[g] == dly_cfg[g]) begin
          dly[g]       = 0;
          rsp_model[g] = 1'b1;
          k_idx        = widx(g, req_addr[g]);
          if (req_rw[g]) mem[g][k_idx] = req_data[g];
          else rsp_data[g] = mem[g][k_idx] ^ DW'(corrupt[g][k_idx]);
        end else begin
          dly[g]++;
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (!(done[0] && done[1]) && c < 3000) begin
      @(negedge sys_clk);
      c++;
    end
    check(name, 64'(done[0] && done[1]), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int   cnt;
    logic found;
    vecs[0] = '{2,  4'b0000, 1'b1, 0, 0, 1'b0};
    vecs[1] = '{2,  4'b0100, 1'b0, 1, 2, 1'b0};
    vecs[2] = '{3,  4'b0001, 1'b0, 1, 0, 1'b0};
    vecs[3] = '{2,  4'b1111, 1'b0, 4, 0, 1'b0};
    vecs[4] = '{15, 4'b0000, 1'b1, 0, 0, 1'b0};
    vecs[5] = '{16, 4'b0000, 1'b0, 0, 0, 1'b1};
    dly_cfg[0] = 2;
    dly_cfg[1] = 2;
    corrupt[0] = '0;
    corrupt[1] = '0;

    repeat (2) @(negedge sys_clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst%0d_flags", g),
            64'({req_valid[g], req_rw[g], busy[g], done[g], pass[g], timeout[g], proto_err[g],
                 err_count[g], first_err_idx[g]}), 64'(0));
      check($sformatf("rst%0d_addr", g), 64'(req_addr[g]), 64'(0));
      check($sformatf("rst%0d_data", g), 64'({req_data[g], first_err_data[g]}), 64'(0));
    end
    #2 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      dly_cfg[1] = vecs[i].dly;
      corrupt[1] = vecs[i].corrupt;
      q0.delete();
      q1.delete();
      push(0, 2 * NW);
      push(1, vecs[i].exp_to ? 1 : 2 * NW);
      pulse_start();
      wait_done($sformatf("v%0d_done", i));
      check($sformatf("v%0d_pass", i), 64'(pass[1]), 64'(vecs[i].exp_pass));
      check($sformatf("v%0d_err", i), 64'(err_count[1]), 64'(vecs[i].exp_err));
      check($sformatf("v%0d_timeout", i), 64'(timeout[1]), 64'(vecs[i].exp_to));
      check($sformatf("v%0d_fidx", i), 64'(first_err_idx[1]), 64'(vecs[i].exp_fidx));
      check($sformatf("v%0d_fdata", i), 64'(first_err_data[1]),
            64'(vecs[i].exp_err > 0 ? data_of(1, vecs[i].exp_fidx) ^ 32'h1 : 32'h0));
      check($sformatf("v%0d_idle", i), 64'({busy[1], req_valid[1], proto_err[1]}), 64'(0));
      check($sformatf("v%0d_m0_pass", i), 64'({pass[0], err_count[0], timeout[0]}), 64'({1'b1, 3'd0, 1'b0}));
      check($sformatf("v%0d_sb_left", i), 64'(q0.size() + q1.size()), 64'(0));
    end

    // Silent memory: timeout must land on the 16th cycle of the first write wait.
    dly_cfg[1] = 1000;
    q0.delete();
    q1.delete();
    push(0, 2 * NW);
    push(1, 1);
    pulse_start();
    cnt = 0;
    for (int c = 0; c < 200 && !timeout[1]; c++) begin
      if (req_valid[1]) cnt++;
      @(negedge sys_clk);
    end
    check("to_cycles", 64'(cnt), 64'(16));
    check("to_flags", 64'({timeout[1], done[1], pass[1], req_valid[1], busy[1]}), 64'(5'b11000));
    wait_done("to_done");

    // Stray ready while idle only raises proto_err.
    @(negedge sys_clk);
    poke[1] = 1'b1;
    @(negedge sys_clk);
    poke[1] = 1'b0;
    check("proto_set", 64'(proto_err[1]), 64'(1));
    check("proto_other", 64'({done[1], timeout[1], busy[1], req_valid[1], err_count[1]}), 64'({4'b1100, 3'd0}));
    check("proto_dut0", 64'(proto_err[0]), 64'(0));

    // Reset while the second read is outstanding, then a clean rerun.
    dly_cfg[1] = 2;
    q0.delete();
    q1.delete();
    push(0, 2 * NW);
    push(1, 2 * NW);
    pulse_start();
    check("start_clears", 64'({proto_err[1], timeout[1], done[1], busy[1]}), 64'(4'b0001));
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge sys_clk);
      found = req_valid[1] && !req_rw[1] && (req_addr[1] == addr_of(1, 1));
    end
    check("reach_rd1", 64'(found), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_flags", 64'({req_valid[1], busy[1], done[1], pass[1]}), 64'(0));
    check("rst_mid_score", 64'({err_count[1], first_err_data[1]}), 64'(0));
    @(negedge sys_clk);
    #2 rst_n = 1'b1;
    q0.delete();
    q1.delete();
    push(0, 2 * NW);
    push(1, 2 * NW);
    pulse_start();
    wait_done("rerun_done");
    check("rerun_pass", 64'({pass[1], pass[0], err_count[1], timeout[1]}), 64'({2'b11, 3'd0, 1'b0}));
    check("rerun_sb_left", 64'(q0.size() + q1.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
